// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: register file geometry,
// writeback request bundle and small helpers.
package rv32i_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

    function automatic logic [5:0] popcount(input logic [NREG-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/wb_arbiter_rv32i.sv
// Two-source writeback arbiter (LSU over ALU) with a registered
// register-file write port.
module wb_arbiter_rv32i
    import rv32i_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    output logic                 alu_ready,
    input  logic                 lsu_valid,
    input  logic [REG_IDX_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]      lsu_data,
    output logic                 lsu_ready,
    output logic                 grant_valid,
    output logic [REG_IDX_W-1:0] grant_rd,
    output logic                 wb_we,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [XLEN-1:0]      wb_wd
);

    wb_req_t alu_req;
    wb_req_t lsu_req;
    wb_req_t grant;

    always_comb begin
        alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
        lsu_req = '{valid: lsu_valid, rd: lsu_rd, data: lsu_data};
        grant   = lsu_req.valid ? lsu_req : alu_req;
    end

    // Loads never wait, so the LSU needs no skid buffering.
    assign lsu_ready   = 1'b1;
    assign alu_ready   = !lsu_valid;
    assign grant_valid = grant.valid;
    assign grant_rd    = grant.rd;

    // x0 writes are consumed but never reach the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_we <= 1'b0;
            wb_rd <= '0;
            wb_wd <= '0;
        end else begin
            wb_we <= grant.valid && (grant.rd != '0);
            wb_rd <= grant.rd;
            wb_wd <= grant.data;
        end
    end

endmodule

// File: rtl/wb_scoreboard_rv32i.sv
// Register scoreboard: stalls RAW/WAW hazards at issue and retires
// pending writes as the arbitrated writeback commits.
module wb_scoreboard_rv32i #(
    parameter int W    = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rs1,
    input  logic [4:0]      iss_rs2,
    input  logic [4:0]      iss_rd,
    input  logic            iss_uses_rd,
    output logic            iss_ready,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [W-1:0]    alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [W-1:0]    lsu_data,
    output logic            lsu_ready,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [W-1:0]    wb_wd,
    output logic [NREG-1:0] busy,
    output logic [5:0]      pending_cnt,
    output logic            err_spurious
);

    import rv32i_pkg::*;

    logic            grant_valid;
    logic [4:0]      grant_rd;
    logic            iss_set;
    logic            spurious;
    logic [NREG-1:0] busy_next;

    wb_arbiter_rv32i u_arb (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .grant_valid (grant_valid),
        .grant_rd    (grant_rd),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_wd       (wb_wd)
    );

    assign iss_ready = !(busy[iss_rs1] || busy[iss_rs2] ||
                         (iss_uses_rd && busy[iss_rd]));

    assign iss_set  = iss_valid && iss_ready && iss_uses_rd &&
                      (iss_rd != '0);
    assign spurious = grant_valid && (grant_rd != '0) && !busy[grant_rd];

    // Set is applied after clear so a same-register collision keeps it busy.
    always_comb begin
        busy_next = busy;
        if (wb_we) begin
            busy_next[wb_rd] = 1'b0;
        end
        if (iss_set) begin
            busy_next[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= '0;
            err_spurious <= 1'b0;
        end else begin
            busy <= busy_next;
            if (spurious) begin
                err_spurious <= 1'b1;
            end
        end
    end

    assign pending_cnt = popcount(busy);

endmodule

// File: tb/tb_wb_scoreboard_rv32i.sv
// Directed self-checking bench for the writeback scoreboard.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_wb_scoreboard_rv32i;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic [4:0]  iss_rd;
    logic        iss_uses_rd;
    logic        iss_ready;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic [31:0] busy;
    logic [5:0]  pending_cnt;
    logic        err_spurious;

    int checks = 0;
    int errors = 0;

    wb_scoreboard_rv32i #(.W(32), .NREG(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .iss_valid    (iss_valid),
        .iss_rs1      (iss_rs1),
        .iss_rs2      (iss_rs2),
        .iss_rd       (iss_rd),
        .iss_uses_rd  (iss_uses_rd),
        .iss_ready    (iss_ready),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .lsu_valid    (lsu_valid),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .lsu_ready    (lsu_ready),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_wd        (wb_wd),
        .busy         (busy),
        .pending_cnt  (pending_cnt),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        iss_valid   = 1'b1;
        iss_rs1     = 5'd0;
        iss_rs2     = 5'd0;
        iss_rd      = rd;
        iss_uses_rd = 1'b1;
    endtask

    task automatic idle();
        iss_valid   = 1'b0;
        iss_rs1     = 5'd0;
        iss_rs2     = 5'd0;
        iss_rd      = 5'd0;
        iss_uses_rd = 1'b0;
        alu_valid   = 1'b0;
        lsu_valid   = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        idle();
        alu_rd   = 5'd0;
        alu_data = 32'd0;
        lsu_rd   = 5'd0;
        lsu_data = 32'd0;
        #2;
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_wd", wb_wd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", pending_cnt, 0);
        chk("rst_err", err_spurious, 0);
        iss_valid = 1'b1;
        #1;
        chk("rst_iss_ready", iss_ready, 1);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_lsu_ready", lsu_ready, 1);
        iss_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // RAW stall released two cycles after the ALU offer.
        issue(5'd5);
        #1;
        chk("raw_first_ready", iss_ready, 1);
        tick();
        chk("raw_busy5", busy, 32'h0000_0020);
        iss_rs1     = 5'd5;
        iss_rd      = 5'd0;
        iss_uses_rd = 1'b0;
        alu_valid   = 1'b1;
        alu_rd      = 5'd5;
        alu_data    = 32'hDEAD_BEEF;
        #1;
        chk("raw_stall", iss_ready, 0);
        chk("raw_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        chk("raw_wb_we", wb_we, 1);
        chk("raw_wb_rd", wb_rd, 5);
        chk("raw_wb_wd", wb_wd, 32'hDEAD_BEEF);
        chk("raw_still_stall", iss_ready, 0);
        tick();
        chk("raw_wb_we_off", wb_we, 0);
        chk("raw_released", iss_ready, 1);
        chk("raw_busy_clr", busy, 0);
        chk("raw_err", err_spurious, 0);
        idle();

        // LSU wins over ALU; ALU offer held and retired next.
        issue(5'd3);
        tick();
        issue(5'd4);
        tick();
        idle();
        chk("prio_cnt2", pending_cnt, 2);
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'h0000_0033;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd4;
        lsu_data  = 32'h0000_0044;
        #1;
        chk("prio_alu_ready0", alu_ready, 0);
        chk("prio_lsu_ready", lsu_ready, 1);
        tick();
        lsu_valid = 1'b0;
        #1;
        chk("prio_wb1_we", wb_we, 1);
        chk("prio_wb1_rd", wb_rd, 4);
        chk("prio_wb1_wd", wb_wd, 32'h0000_0044);
        chk("prio_alu_ready1", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        chk("prio_wb2_we", wb_we, 1);
        chk("prio_wb2_rd", wb_rd, 3);
        chk("prio_wb2_wd", wb_wd, 32'h0000_0033);
        chk("prio_busy", busy, 32'h0000_0008);
        tick();
        chk("prio_busy_clr", busy, 0);
        chk("prio_err", err_spurious, 0);

        // x0 destination never tracked, never written.
        issue(5'd0);
        tick();
        idle();
        chk("x0_busy", busy, 0);
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = 32'h1;
        tick();
        alu_valid = 1'b0;
        chk("x0_wb_we", wb_we, 0);
        tick();
        chk("x0_wb_we2", wb_we, 0);
        chk("x0_err", err_spurious, 0);
        chk("x0_busy2", busy, 0);

        // Issue rd=7 on the edge that retires rd=8.
        issue(5'd8);
        tick();
        idle();
        alu_valid = 1'b1;
        alu_rd    = 5'd8;
        alu_data  = 32'h0000_0088;
        tick();
        alu_valid = 1'b0;
        issue(5'd7);
        #1;
        chk("same_edge_we", wb_we, 1);
        chk("same_edge_ready", iss_ready, 1);
        chk("same_edge_cnt0", pending_cnt, 1);
        tick();
        idle();
        chk("same_edge_busy", busy, 32'h0000_0080);
        chk("same_edge_cnt1", pending_cnt, 1);
        alu_valid = 1'b1;
        alu_rd    = 5'd7;
        tick();
        alu_valid = 1'b0;
        tick();
        chk("same_edge_clr", busy, 0);
        chk("same_edge_err", err_spurious, 0);

        // Writeback to an idle register is still written and flagged.
        lsu_valid = 1'b1;
        lsu_rd    = 5'd9;
        lsu_data  = 32'h0000_0099;
        tick();
        lsu_valid = 1'b0;
        chk("spur_we", wb_we, 1);
        chk("spur_rd", wb_rd, 9);
        chk("spur_wd", wb_wd, 32'h0000_0099);
        chk("spur_err", err_spurious, 1);
        tick();
        chk("spur_we_off", wb_we, 0);
        chk("spur_sticky1", err_spurious, 1);
        tick();
        chk("spur_sticky2", err_spurious, 1);

        // Fill every register, then reset with a write in flight.
        for (int i = 1; i < 32; i++) begin
            issue(i[4:0]);
            #1;
            if (i == 16) begin
                chk("fill_cnt15", pending_cnt, 15);
            end
            tick();
        end
        idle();
        chk("fill_cnt31", pending_cnt, 31);
        chk("fill_busy", busy, 32'hFFFF_FFFE);
        issue(5'd1);
        #1;
        chk("fill_waw_stall", iss_ready, 0);
        iss_valid = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd1;
        alu_data  = 32'h0000_0111;
        tick();
        alu_valid = 1'b0;
        chk("fill_inflight", wb_we, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", wb_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", pending_cnt, 0);
        chk("mid_rst_err", err_spurious, 0);
        tick();
        rst = 1'b0;
        issue(5'd1);
        #1;
        chk("post_rst_ready", iss_ready, 1);
        tick();
        idle();
        chk("post_rst_busy", busy, 32'h0000_0002);
        chk("post_rst_cnt", pending_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
